iir_requant_stage: RTL and testbench
====================================

IIR_REQUANT_STAGE -- requirements
Module: iir_requant_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample/coefficient width; input sum is 2*WIDTH+5 bits signed.
REQ-002 SHALL have parameter FRAC, default 30, coefficient fractional bits removed by requantization; legal range 1 <= FRAC <= 2*WIDTH.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port sum_in, input, 2*WIDTH+5 bits signed, five-operand biquad accumulator result.
REQ-006 SHALL have port in_valid, input, 1 bit, sum_in is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, stage accepts sum_in this cycle.
REQ-008 SHALL have port y_out, output, WIDTH bits signed, requantized filter output.
REQ-009 SHALL have port out_valid, output, 1 bit, y_out is valid.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts y_out.
REQ-011 SHALL have port y_d1, output, WIDTH bits signed, last accepted output y[n-1], feedback to the multiplier stage.
REQ-012 SHALL have port y_d2, output, WIDTH bits signed, y[n-2].
REQ-013 SHALL have port sat_flag, output, 1 bit, sticky: any saturation since reset or clear.
REQ-014 SHALL have port sat_count, output, 16 bits, number of saturated samples, saturating at 16'hFFFF.
REQ-015 SHALL have port sat_clr, input, 1 bit, synchronous clear of sat_flag and sat_count.

Function
REQ-016 SHALL be a 2-stage valid/ready pipeline: S1 = round+shift, S2 = saturate; each stage has a valid bit.
REQ-017 Input handshake occurs when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-018 S2 SHALL load when S1 valid and (!out_valid || out_ready); S1 SHALL load when in_valid and (!s1_valid || S2 loads).
REQ-019 in_ready SHALL equal (!s1_valid || S2 loads); combinational, no dependence on in_valid.
REQ-020 Latency SHALL be exactly 2 cycles from input handshake to out_valid with no stall; throughput 1 sample/cycle.
REQ-021 S1 SHALL compute r = (sum_in + 2^(FRAC-1)) >>> FRAC at full width plus 1 guard bit (round half toward +inf, no wrap).
REQ-022 S2 SHALL clamp r to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; y_out = clamped value, registered.
REQ-023 A sample SHALL count as saturated when clamping changed its value; flagged together with its y_out.
REQ-024 sat_count SHALL increment and sat_flag set on output handshake of a saturated sample; sat_count holds at 16'hFFFF.
REQ-025 sat_clr SHALL take priority over a simultaneous increment: both cleared that cycle, the coincident sample not counted.
REQ-026 On each output handshake: y_d2 <= y_d1, y_d1 <= y_out; otherwise both hold.
REQ-027 While out_valid && !out_ready, y_out, out_valid and S2 contents SHALL hold stable; no sample dropped or duplicated.

Reset
REQ-028 rst_n low SHALL immediately clear s1/s2 valid, out_valid, y_out, y_d1, y_d2, sat_flag, sat_count to 0; in_ready = 1 during and after reset.
REQ-029 Reset mid-stream SHALL discard all in-flight samples; the first handshake after release starts a clean pipeline.

Verification (WIDTH=16, FRAC=14)
REQ-030 sum_in = 49152 (3.0), out_ready=1 -> y_out = 3 exactly 2 cycles later, sat_flag = 0.
REQ-031 Rounding: sum_in = 8192 -> 1; -8192 -> 0; -8193 -> -1; 24575 -> 1.
REQ-032 Saturation: sum_in = 2^36-1 -> 32767; -2^36 -> -32768; sat_count = 2, sat_flag = 1; then sat_clr pulse -> both 0.
REQ-033 Back-pressure: stream 1..6 (x2^14) with out_ready low 3 cycles mid-stream -> outputs 1..6 in order, in_ready low while both stages full.
REQ-034 Feedback: accepted outputs 5, 7, 9 -> after third handshake y_d1 = 9, y_d2 = 7; no change during stall cycles.
REQ-035 rst_n asserted with both stages valid -> out_valid drops asynchronously, all outputs 0; post-release sample 2x2^14 -> y_out = 2, y_d1 = 2 after handshake.

Source files
------------

// File: rtl/iir_requant_stage_if.sv
// Handshake and status bundle for the biquad requantization stage.
// The producer/consumer side uses the master modport, the stage itself uses slave.
interface iir_requant_stage_if #(
   parameter int WIDTH = 32
);
   logic signed [2*WIDTH+4:0] sum_in;
   logic                      in_valid;
   logic                      in_ready;
   logic signed [WIDTH-1:0]   y_out;
   logic                      out_valid;
   logic                      out_ready;
   logic signed [WIDTH-1:0]   y_d1;
   logic signed [WIDTH-1:0]   y_d2;
   logic                      sat_flag;
   logic [15:0]               sat_count;
   logic                      sat_clr;

   modport master (
      output sum_in, in_valid, out_ready, sat_clr,
      input  in_ready, y_out, out_valid, y_d1, y_d2, sat_flag, sat_count
   );

   modport slave (
      input  sum_in, in_valid, out_ready, sat_clr,
      output in_ready, y_out, out_valid, y_d1, y_d2, sat_flag, sat_count
   );
endinterface

// File: rtl/iir_requant_stage.sv
// Requantization back end of a biquad: rounds the wide accumulator result
// down by FRAC bits, saturates to WIDTH bits, and keeps the y[n-1]/y[n-2]
// feedback taps plus saturation statistics. Two-stage valid/ready pipeline.
module iir_requant_stage #(
   parameter int WIDTH = 32,
   parameter int FRAC  = 30
) (
   input logic               clk,
   input logic               rst_n,
   iir_requant_stage_if.slave bus
);
   localparam int SW = 2*WIDTH + 5;
   localparam int RW = SW + 1;

   localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC-1);
   localparam logic signed [RW-1:0] MAXV = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [RW-1:0] MINV = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic                    s1_valid;
   logic signed [RW-1:0]    s1_r;
   logic signed [RW-1:0]    round_r;
   logic signed [WIDTH-1:0] clamp_y;
   logic                    clamp_sat;
   logic                    s2_sat;
   logic                    s1_load;
   logic                    s2_load;
   logic                    out_hs;

   assign s2_load      = s1_valid && (!bus.out_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_load;
   assign s1_load      = bus.in_valid && bus.in_ready;
   assign out_hs       = bus.out_valid && bus.out_ready;

   // Round half toward +inf, one guard bit wide so the bias add cannot wrap
   always_comb begin
      round_r = '0;
      round_r = ($signed({bus.sum_in[SW-1], bus.sum_in}) + HALF) >>> FRAC;
   end

   // Clamp the rounded value into the WIDTH-bit signed range and note whether it moved
   always_comb begin
      clamp_y   = s1_r[WIDTH-1:0];
      clamp_sat = 1'b0;
      if (s1_r > MAXV) begin
         clamp_y   = {1'b0, {(WIDTH-1){1'b1}}};
         clamp_sat = 1'b1;
      end else if (s1_r < MINV) begin
         clamp_y   = {1'b1, {(WIDTH-1){1'b0}}};
         clamp_sat = 1'b1;
      end
   end

   // Stage 1 register: holds the rounded value until stage 2 can take it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_r     <= round_r;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 register: saturated output, frozen while the consumer stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.y_out     <= '0;
         s2_sat        <= 1'b0;
      end else if (s2_load) begin
         bus.out_valid <= 1'b1;
         bus.y_out     <= clamp_y;
         s2_sat        <= clamp_sat;
      end else if (out_hs) begin
         bus.out_valid <= 1'b0;
      end
   end

   // Feedback taps advance only when the consumer actually takes a sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.y_d1 <= '0;
         bus.y_d2 <= '0;
      end else if (out_hs) begin
         bus.y_d1 <= bus.y_out;
         bus.y_d2 <= bus.y_d1;
      end
   end

   // Saturation statistics; a clear wins over a coincident saturated handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sat_flag  <= 1'b0;
         bus.sat_count <= '0;
      end else if (bus.sat_clr) begin
         bus.sat_flag  <= 1'b0;
         bus.sat_count <= '0;
      end else if (out_hs && s2_sat) begin
         bus.sat_flag <= 1'b1;
         if (bus.sat_count != 16'hFFFF) begin
            bus.sat_count <= bus.sat_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_iir_requant_stage.sv
// Scoreboard bench for iir_requant_stage at WIDTH=16, FRAC=14.
module tb_iir_requant_stage;
   localparam int     WIDTH = 16;
   localparam int     FRAC  = 14;
   localparam longint ONE   = 64'sd16384;

   typedef struct {
      longint y;
      bit     sat;
      int     cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   iir_requant_stage_if #(.WIDTH(WIDTH)) bus();

   iir_requant_stage #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   longint pending[$];
   exp_t   sb[$];
   int     vectors     = 0;
   int     miscompares = 0;
   int     cycNum      = 0;
   int     lastLat     = -1;
   longint expCount    = 0;
   bit     lastInReady;
   bit     sawBlocked;

   // Reference: round half up, shift, clamp to signed 16 bits
   function automatic void model(input longint s, output longint y, output bit sat);
      longint r;
      r   = (s + (ONE >>> 1)) >>> FRAC;
      sat = 1'b0;
      y   = r;
      if (r > 32767) begin
         y   = 32767;
         sat = 1'b1;
      end else if (r < -32768) begin
         y   = -32768;
         sat = 1'b1;
      end
   endfunction

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // One clock cycle, entered and left on a falling edge
   task automatic applyStimulus();
      exp_t   e;
      longint y;
      bit     sat;
      bit     popSat;
      popSat       = 1'b0;
      bus.in_valid = (pending.size() != 0);
      bus.sum_in   = (pending.size() != 0) ? 37'(pending[0]) : '0;
      #1;
      lastInReady = bus.in_ready;
      if (bus.in_valid && bus.in_ready) begin
         model(pending[0], y, sat);
         e.y   = y;
         e.sat = sat;
         e.cyc = cycNum;
         sb.push_back(e);
         void'(pending.pop_front());
      end
      if (bus.out_valid && bus.out_ready) begin
         checkOutput("sb_nonempty", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("y_out", bus.y_out, e.y);
            lastLat = cycNum - e.cyc;
            popSat  = e.sat;
         end
      end
      if (bus.sat_clr) expCount = 0;
      else if (popSat && expCount < 65535) expCount++;
      @(negedge clk);
      cycNum++;
   endtask

   task automatic drain(input int budget, input bit randReady);
      int n = 0;
      while ((pending.size() != 0 || sb.size() != 0) && n < budget) begin
         if (randReady) bus.out_ready = ($urandom_range(0, 3) != 0);
         else bus.out_ready = 1'b1;
         applyStimulus();
         n++;
      end
      checkOutput("drain_left", pending.size() + sb.size(), 0);
   endtask

   initial begin
      longint v;
      bus.sum_in    = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.sat_clr   = 1'b0;
      #2;
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_y_out", bus.y_out, 0);
      checkOutput("rst_y_d1", bus.y_d1, 0);
      checkOutput("rst_y_d2", bus.y_d2, 0);
      checkOutput("rst_sat_flag", bus.sat_flag, 0);
      checkOutput("rst_sat_count", bus.sat_count, 0);
      checkOutput("rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_in_ready", bus.in_ready, 1);

      $display("[TB] basic 3.0 sample and latency");
      pending.push_back(49152);
      drain(20, 1'b0);
      checkOutput("latency", lastLat, 2);
      checkOutput("basic_sat_flag", bus.sat_flag, 0);

      $display("[TB] rounding cases");
      pending.push_back(8192);
      pending.push_back(-8192);
      pending.push_back(-8193);
      pending.push_back(24575);
      drain(30, 1'b0);
      checkOutput("stream_latency", lastLat, 2);

      $display("[TB] saturation both rails");
      pending.push_back((64'sd1 <<< 36) - 1);
      pending.push_back(-(64'sd1 <<< 36));
      drain(20, 1'b0);
      checkOutput("sat_count_2", bus.sat_count, 2);
      checkOutput("sat_flag_set", bus.sat_flag, 1);
      bus.sat_clr = 1'b1;
      applyStimulus();
      bus.sat_clr = 1'b0;
      checkOutput("clr_count", bus.sat_count, 0);
      checkOutput("clr_flag", bus.sat_flag, 0);

      $display("[TB] clear coincident with saturated handshake");
      bus.out_ready = 1'b0;
      pending.push_back((64'sd1 <<< 36) - 1);
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("held_out_valid", bus.out_valid, 1);
      bus.sat_clr   = 1'b1;
      bus.out_ready = 1'b1;
      applyStimulus();
      bus.sat_clr = 1'b0;
      checkOutput("prio_count", bus.sat_count, 0);
      checkOutput("prio_flag", bus.sat_flag, 0);
      checkOutput("prio_sb", sb.size(), 0);

      $display("[TB] back-pressure stream 1..6");
      for (int k = 1; k <= 6; k++) pending.push_back(k * ONE);
      sawBlocked = 1'b0;
      for (int i = 0; i < 40 && (pending.size() != 0 || sb.size() != 0); i++) begin
         bus.out_ready = !(i >= 2 && i <= 4);
         applyStimulus();
         if (!bus.out_ready && !lastInReady) sawBlocked = 1'b1;
      end
      checkOutput("bp_in_ready_low", sawBlocked, 1);
      checkOutput("bp_drained", pending.size() + sb.size(), 0);

      $display("[TB] feedback taps");
      pending.push_back(5 * ONE);
      pending.push_back(7 * ONE);
      pending.push_back(9 * ONE);
      drain(20, 1'b0);
      checkOutput("fb_y_d1", bus.y_d1, 9);
      checkOutput("fb_y_d2", bus.y_d2, 7);
      bus.out_ready = 1'b0;
      pending.push_back(11 * ONE);
      for (int i = 0; i < 4; i++) applyStimulus();
      checkOutput("stall_y_d1", bus.y_d1, 9);
      checkOutput("stall_y_d2", bus.y_d2, 7);
      checkOutput("stall_y_out", bus.y_out, 11);
      drain(20, 1'b0);
      checkOutput("fb2_y_d1", bus.y_d1, 11);
      checkOutput("fb2_y_d2", bus.y_d2, 9);

      $display("[TB] random samples with random back-pressure");
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) v = $signed({$urandom, $urandom}) >>> 27;
         else v = $signed({$urandom, $urandom}) >>> 43;
         pending.push_back(v);
      end
      drain(600, 1'b1);
      checkOutput("rand_sat_count", bus.sat_count, expCount);
      checkOutput("rand_sat_flag", bus.sat_flag, longint'(expCount != 0));

      $display("[TB] reset with both stages full");
      bus.out_ready = 1'b0;
      pending.push_back(5 * ONE);
      pending.push_back(6 * ONE);
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("full_in_ready", bus.in_ready, 0);
      checkOutput("full_out_valid", bus.out_valid, 1);
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", bus.out_valid, 0);
      checkOutput("mid_rst_y_out", bus.y_out, 0);
      checkOutput("mid_rst_y_d1", bus.y_d1, 0);
      checkOutput("mid_rst_y_d2", bus.y_d2, 0);
      checkOutput("mid_rst_sat_count", bus.sat_count, 0);
      checkOutput("mid_rst_in_ready", bus.in_ready, 1);
      pending.delete();
      sb.delete();
      expCount = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pending.push_back(2 * ONE);
      drain(20, 1'b0);
      checkOutput("post_rst_latency", lastLat, 2);
      checkOutput("post_rst_y_d1", bus.y_d1, 2);
      checkOutput("post_rst_y_d2", bus.y_d2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
